mem_bist_engine: RTL and testbench

- Synthesizable, parametrised memory self-test engine. It replaces the fixed clear / data=address bench sequence with an on-chip sequencer.
- Drives the single-port memory bus (read, write, addr, data_in) and checks data_out against generated patterns.
- Reports pass/fail, error count and first-failure capture.
- Sits between the host/control logic and the memory, in place of the testbench driver.

---
 rtl/mem_bist_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_bist_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_engine.sv
// mem_bist_engine
// On-chip memory self-test sequencer for a single-port memory. It writes a
// generated pattern, reads it back, and compares each word. It reports
// pass/fail, a saturating error count and the first failing address/data.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a test (accepted only in IDLE or DONE)
//   mode              0=clear, 1=data=address, 2=checkerboard, 3=march
//   stop_on_fail      abort on the first mismatch
//   busy, done, pass  test status; pass is valid while done=1
//   err_count         saturating mismatch count
//   fail_valid        first_fail_addr/first_fail_data hold a capture
//   mem_read, mem_write, mem_addr, mem_data_in  memory bus (all registered)
//   mem_data_out      read data returned RD_LATENCY edges after the read
module mem_bist_engine #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     stop_on_fail,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     fail_valid,
  output logic [ADDR_WIDTH-1:0]    first_fail_addr,
  output logic [DATA_WIDTH-1:0]    first_fail_data,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out
);

  localparam int PAT_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

  // CMP is the last cycle of a read: the returned word sits on mem_data_out
  // and is checked at the edge closing this cycle. With RD_LATENCY=0 that
  // check happens at the end of RD_ISSUE instead, so CMP is never visited.
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, CMP, DONE} state_t;

  // Test element currently being executed.
  typedef enum logic [1:0] {
    E_FILL,      // ascending write of the pattern (march: zeros)
    E_CHECK,     // ascending read/compare for modes 0-2
    E_MARCH_RW,  // march: read expecting 0, then write all-ones
    E_DESC       // march: descending read expecting all-ones
  } elem_t;

  state_t                   state, state_next;
  elem_t                    elem, elem_next;
  logic [ADDR_WIDTH-1:0]    addr, addr_next;
  logic [1:0]               wait_cnt, wait_next;
  logic [1:0]               mode_r, mode_next;
  logic                     stop_r, stop_next;
  logic [ERR_CNT_WIDTH-1:0] err_next;
  logic                     fail_valid_next;
  logic [ADDR_WIDTH-1:0]    ffa_next;
  logic [DATA_WIDTH-1:0]    ffd_next;
  logic [DATA_WIDTH-1:0]    read_expect;
  logic [DATA_WIDTH-1:0]    wr_data_next;
  logic                     compare_now;
  logic                     mismatch;
  logic                     busy_next;
  logic                     pass_next;

  // Alternating bits with bit 0 set (0x55 for an 8-bit word).
  function automatic logic [DATA_WIDTH-1:0] checker_word();
    logic [DATA_WIDTH-1:0] w;
    for (int i = 0; i < DATA_WIDTH; i++) w[i] = (i % 2 == 0);
    return w;
  endfunction

  // Address as data: zero-extended, or truncated to the low DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] addr_word(input logic [ADDR_WIDTH-1:0] a);
    logic [PAT_W-1:0] ext;
    ext = PAT_W'(a);
    return ext[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    case (m)
      2'd1:    p = addr_word(a);
      2'd2:    p = a[0] ? ~checker_word() : checker_word();
      default: p = '0;   // clear, and the march background
    endcase
    return p;
  endfunction

  assign mem_addr = addr;

  // Next-state, counter and result logic.
  always_comb begin
    state_next      = state;
    elem_next       = elem;
    addr_next       = addr;
    wait_next       = wait_cnt;
    mode_next       = mode_r;
    stop_next       = stop_r;
    err_next        = err_count;
    fail_valid_next = fail_valid;
    ffa_next        = first_fail_addr;
    ffd_next        = first_fail_data;
    compare_now     = 1'b0;
    mismatch        = 1'b0;

    case (elem)
      E_MARCH_RW: read_expect = '0;
      E_DESC:     read_expect = '1;
      default:    read_expect = pattern(mode_r, addr);
    endcase

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          mode_next       = mode;
          stop_next       = stop_on_fail;
          err_next        = '0;
          fail_valid_next = 1'b0;
          ffa_next        = '0;
          ffd_next        = '0;
          elem_next       = E_FILL;
          addr_next       = '0;
          wait_next       = '0;
          state_next      = WR;
        end
      end
      WR: begin
        if (elem == E_MARCH_RW) begin
          // Write half of a march read-then-write pair.
          state_next = RD_ISSUE;
          if (addr == '1) elem_next = E_DESC;
          else            addr_next = addr + ADDR_WIDTH'(1);
        end else if (addr == '1) begin
          addr_next  = '0;
          state_next = RD_ISSUE;
          elem_next  = (mode_r == 2'd3) ? E_MARCH_RW : E_CHECK;
        end else begin
          addr_next = addr + ADDR_WIDTH'(1);
        end
      end
      RD_ISSUE: begin
        if (RD_LATENCY == 0) begin
          compare_now = 1'b1;
        end else if (RD_LATENCY == 1) begin
          state_next = CMP;
        end else begin
          wait_next  = '0;
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Holds RD_LATENCY-1 cycles; CMP is the final wait cycle.
        if (int'(wait_cnt) >= RD_LATENCY - 2) state_next = CMP;
        else                                  wait_next  = wait_cnt + 2'd1;
      end
      CMP: compare_now = 1'b1;
    endcase

    // Check the returned word and pick the next operation of the element.
    if (compare_now) begin
      mismatch = (mem_data_out !== read_expect);
      if (mismatch) begin
        if (err_count != '1) err_next = err_count + ERR_CNT_WIDTH'(1);
        if (!fail_valid) begin
          fail_valid_next = 1'b1;
          ffa_next        = addr;
          ffd_next        = mem_data_out;
        end
      end
      if (mismatch && stop_r) begin
        state_next = DONE;
      end else begin
        case (elem)
          E_CHECK: begin
            if (addr == '1) state_next = DONE;
            else begin
              addr_next  = addr + ADDR_WIDTH'(1);
              state_next = RD_ISSUE;
            end
          end
          E_MARCH_RW: state_next = WR;
          E_DESC: begin
            if (addr == '0) state_next = DONE;
            else begin
              addr_next  = addr - ADDR_WIDTH'(1);
              state_next = RD_ISSUE;
            end
          end
          default: state_next = DONE;
        endcase
      end
    end

    wr_data_next = (elem_next == E_MARCH_RW) ? '1 : pattern(mode_next, addr_next);
    busy_next    = (state_next == WR) || (state_next == RD_ISSUE) ||
                   (state_next == RD_WAIT) || (state_next == CMP);
    pass_next    = (state_next == DONE) && (err_next == '0);
  end

  // State and all outputs are registered from the next-state values, so no
  // input reaches an output without passing through a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      elem            <= E_FILL;
      addr            <= '0;
      wait_cnt        <= '0;
      mode_r          <= '0;
      stop_r          <= 1'b0;
      err_count       <= '0;
      fail_valid      <= 1'b0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_data_in     <= '0;
    end else begin
      state           <= state_next;
      elem            <= elem_next;
      addr            <= addr_next;
      wait_cnt        <= wait_next;
      mode_r          <= mode_next;
      stop_r          <= stop_next;
      err_count       <= err_next;
      fail_valid      <= fail_valid_next;
      first_fail_addr <= ffa_next;
      first_fail_data <= ffd_next;
      busy            <= busy_next;
      done            <= (state_next == DONE);
      pass            <= pass_next;
      mem_read        <= (state_next == RD_ISSUE);
      mem_write       <= (state_next == WR);
      mem_data_in     <= (state_next == WR) ? wr_data_next : '0;
    end
  end

endmodule

// File: tb/tb_mem_bist_engine.sv
// tb_mem_bist_engine
// Self-checking bench for mem_bist_engine. A behavioural memory (with an
// optional stuck-low fault) sits on the bus of a RD_LATENCY=1 engine; a
// second engine built with RD_LATENCY=0 uses an asynchronous-read memory.
// Expected bus writes/reads are queued when a test is started and consumed
// by a bus monitor; end-of-test status is compared against constants.
module tb_mem_bist_engine;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int EW    = 16;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          stop_on_fail;
  logic          busy, done, pass, fail_valid;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_fail_addr;
  logic [DW-1:0] first_fail_data;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  logic          start0;
  logic [1:0]    mode0;
  logic          stop0;
  logic          busy0, done0, pass0, fail_valid0;
  logic [EW-1:0] err_count0;
  logic [AW-1:0] ffa0;
  logic [DW-1:0] ffd0;
  logic          mem_read0, mem_write0;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] mem_data_in0, mem_data_out0;

  int n_asserts = 0;
  int n_fail    = 0;
  int busy_cycles  = 0;
  int busy0_cycles = 0;

  logic [AW+DW-1:0] exp_wr[$];
  logic [AW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] wr_item;
  logic [AW-1:0]    rd_item;

  logic          fault_en   = 1'b0;
  logic [AW-1:0] fault_addr = '0;
  logic [DW-1:0] fault_mask = '0;
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] rd_q = '0;

  always #5 clk = ~clk;

  mem_bist_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stop_on_fail(stop_on_fail),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_valid(fail_valid),
    .first_fail_addr(first_fail_addr), .first_fail_data(first_fail_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out));

  mem_bist_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(0), .ERR_CNT_WIDTH(EW)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode0), .stop_on_fail(stop0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0), .fail_valid(fail_valid0),
    .first_fail_addr(ffa0), .first_fail_data(ffd0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
    .mem_data_in(mem_data_in0), .mem_data_out(mem_data_out0));

  // One-cycle registered-read memory; the fault forces masked bits low on read.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read) rd_q <= (fault_en && mem_addr == fault_addr) ? (mem[mem_addr] & ~fault_mask)
                                                               : mem[mem_addr];
  end
  assign mem_data_out = rd_q;

  // Asynchronous-read memory for the zero-latency engine.
  always @(posedge clk) if (mem_write0) mem0[mem_addr0] <= mem_data_in0;
  assign mem_data_out0 = mem0[mem_addr0];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] patternOf(input logic [1:0] m, input int a);
    case (m)
      2'd1:    return DW'(a);
      2'd2:    return (a % 2 == 1) ? 8'hAA : 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  // Bus monitor: consumes the scoreboard queues as strobes appear.
  always @(negedge clk) begin
    if (busy)  busy_cycles++;
    if (busy0) busy0_cycles++;
    if (!rst && (mem_write || mem_read)) begin
      checkOutput("bus_rw_exclusive", 32'(mem_write & mem_read), 32'd0);
      if (mem_write) begin
        checkOutput("write_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          wr_item = exp_wr.pop_front();
          checkOutput("write_addr", 32'(mem_addr), 32'(wr_item[AW+DW-1:DW]));
          checkOutput("write_data", 32'(mem_data_in), 32'(wr_item[DW-1:0]));
        end
      end
      if (mem_read) begin
        checkOutput("read_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) begin
          rd_item = exp_rd.pop_front();
          checkOutput("read_addr", 32'(mem_addr), 32'(rd_item));
        end
      end
    end
  end

  // Queue the expected bus traffic, then pulse start for one edge.
  task automatic applyStimulus(input logic [1:0] m, input logic s, input int last_rd);
    exp_wr.delete();
    exp_rd.delete();
    for (int a = 0; a < DEPTH; a++) exp_wr.push_back({AW'(a), patternOf(m, a)});
    if (m == 2'd3) begin
      for (int a = 0; a < DEPTH; a++) begin
        exp_rd.push_back(AW'(a));
        exp_wr.push_back({AW'(a), 8'hFF});
      end
      for (int a = DEPTH - 1; a >= 0; a--) exp_rd.push_back(AW'(a));
    end else begin
      for (int a = 0; a <= last_rd; a++) exp_rd.push_back(AW'(a));
    end
    busy_cycles  = 0;
    mode         = m;
    stop_on_fail = s;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_reached", 32'(done), 32'd1);
  endtask

  task automatic checkResults(input string tag, input int exp_busy, input logic exp_pass,
                              input int exp_err, input logic exp_fv,
                              input logic [AW-1:0] exp_ffa, input logic [DW-1:0] exp_ffd);
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    checkOutput({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    checkOutput({tag, "_fail_valid"}, 32'(fail_valid), 32'(exp_fv));
    checkOutput({tag, "_ff_addr"}, 32'(first_fail_addr), 32'(exp_ffa));
    checkOutput({tag, "_ff_data"}, 32'(first_fail_data), 32'(exp_ffd));
    checkOutput({tag, "_strobes"}, 32'({mem_read, mem_write}), 32'd0);
    checkOutput({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    checkOutput({tag, "_reads_left"}, 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
    checkOutput({tag, "_err_count"}, 32'(err_count), 32'd0);
    checkOutput({tag, "_fail_valid"}, 32'(fail_valid), 32'd0);
    checkOutput({tag, "_ff_addr"}, 32'(first_fail_addr), 32'd0);
    checkOutput({tag, "_ff_data"}, 32'(first_fail_data), 32'd0);
    checkOutput({tag, "_strobes"}, 32'({mem_read, mem_write}), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_data_in"}, 32'(mem_data_in), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; stop_on_fail = 1'b0;
    start0 = 1'b0; mode0 = 2'd0; stop0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    $display("[TB] mode 0 clear");
    applyStimulus(2'd0, 1'b0, DEPTH - 1);
    waitDone(400);
    checkResults("mode0", 96, 1'b1, 0, 1'b0, 5'd0, 8'h00);

    $display("[TB] mode 1 with bit 3 stuck low at address 9");
    fault_en = 1'b1; fault_addr = 5'd9; fault_mask = 8'h08;
    applyStimulus(2'd1, 1'b0, DEPTH - 1);
    waitDone(400);
    checkResults("mode1_fault", 96, 1'b0, 1, 1'b1, 5'd9, 8'h01);
    fault_en = 1'b0;

    $display("[TB] mode 2 checkerboard");
    applyStimulus(2'd2, 1'b0, DEPTH - 1);
    waitDone(400);
    checkResults("mode2", 96, 1'b1, 0, 1'b0, 5'd0, 8'h00);

    $display("[TB] mode 3 march");
    applyStimulus(2'd3, 1'b0, DEPTH - 1);
    waitDone(800);
    checkResults("mode3", 192, 1'b1, 0, 1'b0, 5'd0, 8'h00);

    $display("[TB] stop_on_fail, mode 1, fault at address 4");
    fault_en = 1'b1; fault_addr = 5'd4; fault_mask = 8'h04;
    applyStimulus(2'd1, 1'b1, 4);
    waitDone(400);
    checkResults("stop_on_fail", 42, 1'b0, 1, 1'b1, 5'd4, 8'h00);
    fault_en = 1'b0;

    $display("[TB] reset in cycle 40 of a mode 0 test");
    applyStimulus(2'd0, 1'b0, DEPTH - 1);
    repeat (39) @(posedge clk);
    #1;
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkAllZero("mid_rst");
    rst = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_idle_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_idle_done", 32'(done), 32'd0);

    $display("[TB] start pulsed while busy");
    applyStimulus(2'd0, 1'b0, DEPTH - 1);
    repeat (20) @(posedge clk);
    #1;
    mode = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 2'd0;
    waitDone(400);
    checkResults("start_busy", 96, 1'b1, 0, 1'b0, 5'd0, 8'h00);

    $display("[TB] RD_LATENCY=0 engine, mode 0");
    busy0_cycles = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int n = 0; n < 300 && !done0; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("lat0_done", 32'(done0), 32'd1);
    checkOutput("lat0_busy_cycles", 32'(busy0_cycles), 32'd64);
    checkOutput("lat0_pass", 32'(pass0), 32'd1);
    checkOutput("lat0_err_count", 32'(err_count0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
